// File: rtl/dma_axi64_rd_arb.sv
// Round-robin arbiter sharing one AXI read-address channel among four DMA channels.
// Optional macro DMA_AXI64_RD_ARB_PRIO0_EN gives channel 0 absolute priority.
module dma_axi64_rd_arb (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   ch_req,
  input  logic [127:0] ch_addr,
  input  logic [15:0]  ch_len,
  input  logic [7:0]   ch_size,
  output logic [3:0]   ch_ack,
  output logic [1:0]   ARID,
  output logic [31:0]  ARADDR,
  output logic [3:0]   ARLEN,
  output logic [1:0]   ARSIZE,
  output logic         ARVALID,
  input  logic         ARREADY,
  input  logic         RVALID,
  input  logic         RREADY,
  input  logic         RLAST,
  output logic         idle
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [2:0] outstanding;
  logic [1:0] winner;
  logic       start;
  logic       ar_hs;
  logic       r_done;

  // First requester at or after p, wrapping 3->0.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
`ifdef DMA_AXI64_RD_ARB_PRIO0_EN
    winner = ch_req[0] ? 2'd0 : rr_pick(ch_req, ptr);
`else
    winner = rr_pick(ch_req, ptr);
`endif
  end

  assign ARVALID = (state == ISSUE);
  assign ar_hs   = ARVALID & ARREADY;
  // RLAST with nothing outstanding is ignored so the counter cannot wrap.
  assign r_done  = RVALID & RREADY & RLAST & (outstanding != 3'd0);
  assign start   = (state == IDLE) & (|ch_req) & (outstanding < 3'd4);
  assign ch_ack  = ar_hs ? (4'b0001 << ARID) : 4'b0000;
  assign idle    = (state == IDLE) & (outstanding == 3'd0) & (ch_req == 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ARID   <= 2'd0;
      ARADDR <= 32'd0;
      ARLEN  <= 4'd0;
      ARSIZE <= 2'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= ISSUE;
          ARID   <= winner;
          ARADDR <= ch_addr[winner*32 +: 32];
          ARLEN  <= ch_len[winner*4 +: 4];
          ARSIZE <= ch_size[winner*2 +: 2];
        end
        ISSUE: if (ARREADY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (ar_hs) begin
`ifdef DMA_AXI64_RD_ARB_PRIO0_EN
      if (ARID != 2'd0) ptr <= ARID + 2'd1;
`else
      ptr <= ARID + 2'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= 3'd0;
    end else begin
      case ({ar_hs, r_done})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi64_rd_arb.sv
// Scoreboard bench for dma_axi64_rd_arb: expected AR commands queued at stimulus time,
// checked against every AR handshake observed on the falling edge.
module tb_dma_axi64_rd_arb;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   ch_req = '0;
  logic [127:0] ch_addr = '0;
  logic [15:0]  ch_len = '0;
  logic [7:0]   ch_size = '0;
  logic [3:0]   ch_ack;
  logic [1:0]   ARID;
  logic [31:0]  ARADDR;
  logic [3:0]   ARLEN;
  logic [1:0]   ARSIZE;
  logic         ARVALID;
  logic         ARREADY = 1'b0;
  logic         RVALID = 1'b0;
  logic         RREADY = 1'b0;
  logic         RLAST = 1'b0;
  logic         idle;

  dma_axi64_rd_arb dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_size(ch_size), .ch_ack(ch_ack), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY), .RVALID(RVALID),
    .RREADY(RREADY), .RLAST(RLAST), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  size;
  } ar_t;

  ar_t         sb[$];
  ar_t         mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] t_addr[4];
  logic [3:0]  t_len[4];
  logic [1:0]  t_size[4];
  int          order[5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int n, input logic [31:0] a, input logic [3:0] l, input logic [1:0] s);
    t_addr[n] = a; t_len[n] = l; t_size[n] = s;
    ch_addr[n*32 +: 32] = a;
    ch_len[n*4 +: 4]    = l;
    ch_size[n*2 +: 2]   = s;
  endtask

  task automatic expect_grant(input int n);
    ar_t e;
    e.id = 2'(n); e.addr = t_addr[n]; e.len = t_len[n]; e.size = t_size[n];
    sb.push_back(e);
  endtask

  task automatic wait_hs(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ARVALID && ARREADY) found = 1'b1;
      else step();
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic pulse_rlast();
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    step();
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_req = 4'b0; ARREADY = 1'b0;
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && ARVALID && ARREADY) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("arid",   64'(ARID),   64'(mon_e.id));
        check("araddr", 64'(ARADDR), 64'(mon_e.addr));
        check("arlen",  64'(ARLEN),  64'(mon_e.len));
        check("arsize", 64'(ARSIZE), 64'(mon_e.size));
        check("ch_ack", 64'(ch_ack), 64'(4'b0001 << mon_e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2 reset = 1'b1;
    #1;
    check("rst_arvalid", 64'(ARVALID), 64'd0);
    check("rst_arid",    64'(ARID),    64'd0);
    check("rst_araddr",  64'(ARADDR),  64'd0);
    check("rst_arlen",   64'(ARLEN),   64'd0);
    check("rst_arsize",  64'(ARSIZE),  64'd0);
    check("rst_ack",     64'(ch_ack),  64'd0);
    check("rst_idle",    64'(idle),    64'd1);
    step();
    reset = 1'b0;

    // Single channel 0 command
    set_ch(0, 32'h0000_1000, 4'd3, 2'd3);
    ARREADY = 1'b1;
    ch_req = 4'b0001;
    expect_grant(0);
    #1;
    check("t1_pre_valid", 64'(ARVALID), 64'd0);
    step();
    check("t1_valid",  64'(ARVALID), 64'd1);
    check("t1_araddr", 64'(ARADDR),  64'h1000);
    ch_req = 4'b0000;
    #1;
    check("t1_ack", 64'(ch_ack), 64'b0001);
    step();
    check("t1_post_valid", 64'(ARVALID), 64'd0);
    check("t1_post_ack",   64'(ch_ack),  64'd0);
    check("t1_busy",       64'(idle),    64'd0);
    pulse_rlast();
    check("t1_idle", 64'(idle), 64'd1);

    // RLAST with nothing outstanding must not wrap the counter
    pulse_rlast();
    check("uf_idle", 64'(idle), 64'd1);
    set_ch(3, 32'h3333_0000, 4'd15, 2'd1);
    expect_grant(3);
    ch_req = 4'b1000;
    wait_hs("uf_hs");
    ch_req = 4'b0000;
    step();
    pulse_rlast();
    check("uf_idle2", 64'(idle), 64'd1);

    // Round-robin across all four channels
    do_reset();
    for (int n = 0; n < 4; n++) set_ch(n, 32'h2000 + 32'(n) * 32'h100, 4'(n + 4), 2'(n));
`ifdef DMA_AXI64_RD_ARB_PRIO0_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int k = 0; k < 5; k++) expect_grant(order[k]);
    ARREADY = 1'b1;
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_hs("rr_hs");
      step();
      check("rr_gap", 64'(ARVALID), 64'd0);
      if (k == 4) ch_req = 4'b0000;
      pulse_rlast();
    end
    check("rr_drain", 64'(sb.size()), 64'd0);
    check("rr_idle",  64'(idle),      64'd1);

    // ARREADY stall: payload latched and stable, no early ack
    do_reset();
    set_ch(2, 32'hCAFE_0040, 4'd7, 2'd2);
    expect_grant(2);
    ch_req = 4'b0100;
    step();
    for (int i = 0; i < 5; i++) begin
      check("st_valid",  64'(ARVALID), 64'd1);
      check("st_arid",   64'(ARID),    64'd2);
      check("st_araddr", 64'(ARADDR),  64'hCAFE_0040);
      check("st_arlen",  64'(ARLEN),   64'd7);
      check("st_ack",    64'(ch_ack),  64'd0);
      if (i == 1) begin
        ch_addr[64 +: 32] = 32'hDEAD_0000;
        ch_len[8 +: 4] = 4'd1;
        ch_req = 4'b0000;
      end
      step();
    end
    ARREADY = 1'b1;
    #1;
    check("st_hs_ack", 64'(ch_ack), 64'b0100);
    step();
    check("st_post_valid", 64'(ARVALID), 64'd0);
    check("st_post_ack",   64'(ch_ack),  64'd0);
    pulse_rlast();
    check("st_idle", 64'(idle), 64'd1);

    // Outstanding limit of four
    do_reset();
    set_ch(0, 32'h0400_0000, 4'd1, 2'd3);
    ARREADY = 1'b1;
    ch_req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      expect_grant(0);
      wait_hs("cap_hs");
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("cap_blk_valid", 64'(ARVALID), 64'd0);
      check("cap_blk_idle",  64'(idle),    64'd0);
      check("cap_blk_ack",   64'(ch_ack),  64'd0);
      step();
    end
    expect_grant(0);
    pulse_rlast();
    wait_hs("cap_resume");
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
    expect_grant(0);
    step();
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
    wait_hs("cap_coinc");
    step();
    for (int i = 0; i < 3; i++) begin
      check("cap_full_valid", 64'(ARVALID), 64'd0);
      step();
    end
    ch_req = 4'b0000;
    for (int i = 0; i < 3; i++) pulse_rlast();
    check("cap_busy", 64'(idle), 64'd0);
    pulse_rlast();
    check("cap_idle", 64'(idle), 64'd1);
    check("cap_drain", 64'(sb.size()), 64'd0);

    // Reset while a command is being presented
    do_reset();
    set_ch(1, 32'h1111_2220, 4'd2, 2'd1);
    expect_grant(1);
    ARREADY = 1'b1;
    ch_req = 4'b0010;
    wait_hs("ra_hs");
    step();
    ARREADY = 1'b0;
    step();
    check("ra_pre_valid", 64'(ARVALID), 64'd1);
    reset = 1'b1;
    ch_req = 4'b0000;
    #1;
    check("ra_valid",  64'(ARVALID), 64'd0);
    check("ra_araddr", 64'(ARADDR),  64'd0);
    check("ra_idle",   64'(idle),    64'd1);
    ARREADY = 1'b1;
    #1;
    check("ra_ack", 64'(ch_ack), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("ra_post_valid", 64'(ARVALID), 64'd0);
    check("ra_post_idle",  64'(idle),    64'd1);
    check("ra_drain",      64'(sb.size()), 64'd0);

    // Two requesters: alternation, or channel 0 priority when enabled
    do_reset();
    set_ch(0, 32'h5000_0000, 4'd0, 2'd0);
    set_ch(1, 32'h5100_0000, 4'd8, 2'd2);
`ifdef DMA_AXI64_RD_ARB_PRIO0_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1, 0};
`endif
    for (int k = 0; k < 4; k++) expect_grant(order[k]);
    ARREADY = 1'b1;
    ch_req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_hs("p2_hs");
      step();
      if (k == 3) ch_req = 4'b0000;
      pulse_rlast();
    end
    check("p2_drain", 64'(sb.size()), 64'd0);
    check("p2_idle",  64'(idle),      64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
